window3x3_stream_filter: RTL and testbench

// - Streaming 3x3 neighbourhood filter for greyscale frames. Accepts pixels in raster order over a

---
 rtl/window3x3_stream_filter_pkg.sv | 17 +
 rtl/window3x3_stream_filter_line_buffer.sv | 21 ++
 rtl/window3x3_stream_filter.sv | 196 +++++++++++++++++++
 tb/tb_window3x3_stream_filter.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/window3x3_stream_filter_pkg.sv
// Shared encodings for the 3x3 streaming window filter: kernel select and control states.
package window3x3_stream_filter_pkg;

    typedef enum logic [1:0] {
        MODE_MEDIAN = 2'b00,
        MODE_SOBEL  = 2'b01,
        MODE_PASS   = 2'b10,
        MODE_GAUSS  = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        FLUSH  = 2'd2
    } state_e;

endpackage

// File: rtl/window3x3_stream_filter_line_buffer.sv
// One image line of delay: dout is the pixel pushed DEPTH pushes ago (read before write).
module window3x3_stream_filter_line_buffer #(
    parameter int DEPTH = 100,
    parameter int PIX_W = 8
) (
    input  logic             clk,
    input  logic             push,
    input  logic [PIX_W-1:0] din,
    output logic [PIX_W-1:0] dout
);

    logic [DEPTH-1:0][PIX_W-1:0] sr;

    // Contents are only consumed once a full line has been pushed, so no reset is needed.
    always_ff @(posedge clk) begin
        if (push) sr <= {sr[DEPTH-2:0], din};
    end

    assign dout = sr[DEPTH-1];

endmodule

// File: rtl/window3x3_stream_filter.sv
// Raster-order 3x3 neighbourhood filter (median / sobel / passthrough / gaussian) with
// valid/ready on both sides, two line buffers and frame start/done handshake.
module window3x3_stream_filter
    import window3x3_stream_filter_pkg::*;
#(
    parameter int               PIX_W      = 8,
    parameter int               IMG_W      = 100,
    parameter int               IMG_H      = 100,
    parameter int               ADDR_W     = 14,
    parameter logic [PIX_W-1:0] BORDER_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PIX_W-1:0]  in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PIX_W-1:0]  out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic              busy,
    output logic              frame_done
);

    localparam int SW = PIX_W + 4;
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [ADDR_W-1:0] LAST     = ADDR_W'(IMG_W * IMG_H - 1);
    localparam logic [ADDR_W-1:0] PRIME    = ADDR_W'(IMG_W + 1);
    localparam logic [CW-1:0]     COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0]     ROW_LAST = RW'(IMG_H - 1);

    typedef logic [8:0][PIX_W-1:0] win9_t;

    state_e                       state, state_nxt;
    mode_e                        mode_q;
    logic [ADDR_W-1:0]            in_cnt, out_cnt;
    logic [RW-1:0]                pr;
    logic [CW-1:0]                pc;
    logic [2:0][1:0][PIX_W-1:0]   wreg;
    logic [2:0][PIX_W-1:0]        newcol;
    logic [1:0][PIX_W-1:0]        lb_din, lb_dout;
    win9_t                        p;
    logic                         in_fire, out_fire, last_out, produce, interior;
    logic [PIX_W-1:0]             kern;

    function automatic logic [SW-1:0] zx(input logic [PIX_W-1:0] v);
        return {4'b0, v};
    endfunction

    // Exact median: the element with at most four strictly smaller and at least five
    // smaller-or-equal neighbours; every candidate satisfying that has the same value.
    function automatic logic [PIX_W-1:0] median9(input win9_t v);
        logic [PIX_W-1:0] m;
        int lt, le;
        m = v[4];
        for (int i = 0; i < 9; i++) begin
            lt = 0;
            le = 0;
            for (int j = 0; j < 9; j++) begin
                if (v[j] < v[i])  lt++;
                if (v[j] <= v[i]) le++;
            end
            if (lt <= 4 && le >= 5) m = v[i];
        end
        return m;
    endfunction

    function automatic logic [PIX_W-1:0] sobel9(input win9_t v);
        logic signed [SW-1:0] gx, gy;
        logic [SW-1:0]        ax, ay, mag;
        gx  = $signed((zx(v[2]) + (zx(v[5]) << 1) + zx(v[8])) -
                      (zx(v[0]) + (zx(v[3]) << 1) + zx(v[6])));
        gy  = $signed((zx(v[6]) + (zx(v[7]) << 1) + zx(v[8])) -
                      (zx(v[0]) + (zx(v[1]) << 1) + zx(v[2])));
        ax  = gx[SW-1] ? -gx : gx;
        ay  = gy[SW-1] ? -gy : gy;
        mag = ax + ay;
        return (|mag[SW-1:PIX_W]) ? '1 : mag[PIX_W-1:0];
    endfunction

    function automatic logic [PIX_W-1:0] gauss9(input win9_t v);
        logic [SW-1:0] s;
        s = zx(v[0]) + (zx(v[1]) << 1) + zx(v[2]) +
            (zx(v[3]) << 1) + (zx(v[4]) << 2) + (zx(v[5]) << 1) +
            zx(v[6]) + (zx(v[7]) << 1) + zx(v[8]);
        return s[SW-1:4];
    endfunction

    // Row r-1 comes out of the second buffer, row r out of the first, row r+1 is live input.
    assign lb_din[0] = in_data;
    assign lb_din[1] = lb_dout[0];

    for (genvar g = 0; g < 2; g++) begin : g_lb
        window3x3_stream_filter_line_buffer #(
            .DEPTH (IMG_W),
            .PIX_W (PIX_W)
        ) u_lb (
            .clk  (clk),
            .push (in_fire),
            .din  (lb_din[g]),
            .dout (lb_dout[g])
        );
    end

    assign newcol[0] = lb_dout[1];
    assign newcol[1] = lb_dout[0];
    assign newcol[2] = in_data;

    // Window as it will be after this push; the result registers in the same cycle.
    always_comb begin
        for (int r = 0; r < 3; r++) begin
            p[3*r]     = wreg[r][0];
            p[3*r + 1] = wreg[r][1];
            p[3*r + 2] = newcol[r];
        end
    end

    always_ff @(posedge clk) begin
        if (in_fire) begin
            for (int r = 0; r < 3; r++) begin
                wreg[r][0] <= wreg[r][1];
                wreg[r][1] <= newcol[r];
            end
        end
    end

    always_comb begin
        case (mode_q)
            MODE_MEDIAN: kern = median9(p);
            MODE_SOBEL:  kern = sobel9(p);
            MODE_PASS:   kern = p[4];
            default:     kern = gauss9(p);
        endcase
    end

    assign in_ready = (state == STREAM) && (!out_valid || out_ready);
    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;
    assign last_out = (out_cnt == LAST);
    assign produce  = (in_fire && in_cnt >= PRIME) ||
                      (state == FLUSH && (!out_valid || (out_ready && !last_out)));
    assign interior = (pr != '0) && (pr != ROW_LAST) && (pc != '0) && (pc != COL_LAST);
    assign busy     = (state != IDLE);
    assign out_addr = out_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = STREAM;
            STREAM:  if (in_fire && in_cnt == LAST) state_nxt = FLUSH;
            FLUSH:   if (out_fire && last_out) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // pr/pc track the position of the next output to be produced, not the accepted one.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mode_q     <= MODE_MEDIAN;
            in_cnt     <= '0;
            out_cnt    <= '0;
            pr         <= '0;
            pc         <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= (state == FLUSH) && out_fire && last_out;
            if (state == IDLE && start) begin
                mode_q  <= mode_e'(mode);
                in_cnt  <= '0;
                out_cnt <= '0;
                pr      <= '0;
                pc      <= '0;
            end
            if (in_fire)  in_cnt  <= (in_cnt == LAST) ? '0 : in_cnt + 1'b1;
            if (out_fire) out_cnt <= last_out ? '0 : out_cnt + 1'b1;
            if (produce) begin
                out_data <= interior ? kern : BORDER_VAL;
                pc       <= (pc == COL_LAST) ? '0 : pc + 1'b1;
                if (pc == COL_LAST) pr <= (pr == ROW_LAST) ? '0 : pr + 1'b1;
            end
            if (produce)       out_valid <= 1'b1;
            else if (out_fire) out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_window3x3_stream_filter.sv
// Directed + randomized bench for window3x3_stream_filter on an 8x6 frame with a
// sort/arithmetic reference model of the four kernels.
module tb_window3x3_stream_filter;

    localparam int W  = 8;
    localparam int H  = 6;
    localparam int N  = W * H;
    localparam int AW = 6;

    logic          clk = 1'b0;
    logic          rst, start, in_valid, in_ready, out_valid, out_ready, busy, frame_done;
    logic [1:0]    mode;
    logic [7:0]    in_data, out_data;
    logic [AW-1:0] out_addr;

    int errors = 0;
    int checks = 0;
    int img [N];
    int got [N];
    int ref_q [N];

    always #5 clk = ~clk;

    window3x3_stream_filter #(
        .PIX_W      (8),
        .IMG_W      (W),
        .IMG_H      (H),
        .ADDR_W     (AW),
        .BORDER_VAL (8'h00)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .mode       (mode),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_addr   (out_addr),
        .busy       (busy),
        .frame_done (frame_done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, want);
        end
    endtask

    function automatic int model_px(input int r, input int c, input logic [1:0] md);
        int w [9];
        int q [$];
        int gx, gy, s;
        if (r == 0 || r == H - 1 || c == 0 || c == W - 1) return 0;
        for (int i = 0; i < 9; i++) w[i] = img[(r - 1 + i / 3) * W + (c - 1 + i % 3)];
        case (md)
            2'b00: begin
                for (int i = 0; i < 9; i++) q.push_back(w[i]);
                q.sort();
                return q[4];
            end
            2'b01: begin
                gx = (w[2] + 2 * w[5] + w[8]) - (w[0] + 2 * w[3] + w[6]);
                gy = (w[6] + 2 * w[7] + w[8]) - (w[0] + 2 * w[1] + w[2]);
                s  = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
                return s > 255 ? 255 : s;
            end
            2'b10:   return w[4];
            default: return (w[0] + 2 * w[1] + w[2] + 2 * w[3] + 4 * w[4] + 2 * w[5] +
                             w[6] + 2 * w[7] + w[8]) / 16;
        endcase
    endfunction

    task automatic run_frame(input logic [1:0] md, input int p_rdy, input int p_vld,
                             input int mid_start, input int rst_at, input bit start_end);
        int n_in, n_out;
        bit done, seen, stalled, busy_drop, aborted;
        logic [7:0]    hold_d;
        logic [AW-1:0] hold_a;
        n_in = 0; n_out = 0; done = 0; seen = 0; stalled = 0; busy_drop = 0; aborted = 0;
        hold_d = '0; hold_a = '0;
        @(negedge clk);
        start = 1'b1;
        mode  = md;
        @(negedge clk);
        start = 1'b0;
        mode  = ~md;
        #1 check("busy_after_start", 32'(busy), 1);
        for (int cyc = 0; cyc < 3000 && !done && !aborted; cyc++) begin
            start = (mid_start >= 0 && n_in == mid_start);
            if (start) mode = md ^ 2'b01;
            out_ready = ($urandom_range(99) < p_rdy);
            in_valid  = (n_in < N) && ($urandom_range(99) < p_vld);
            in_data   = 8'(img[n_in < N ? n_in : 0]);
            #1;
            if (rst_at >= 0 && n_in == rst_at) begin
                rst = 1'b0;
                #1;
                check("rst_in_ready",   32'(in_ready),   0);
                check("rst_out_valid",  32'(out_valid),  0);
                check("rst_out_data",   32'(out_data),   0);
                check("rst_out_addr",   32'(out_addr),   0);
                check("rst_busy",       32'(busy),       0);
                check("rst_frame_done", 32'(frame_done), 0);
                aborted = 1;
            end else begin
                if (!busy) busy_drop = 1;
                if (stalled) begin
                    check("stall_data", 32'(out_data), 32'(hold_d));
                    check("stall_addr", 32'(out_addr), 32'(hold_a));
                end
                if (out_valid && !out_ready) check("no_input_while_stalled", 32'(in_ready), 0);
                if (out_valid && !seen) begin
                    seen = 1;
                    check("first_out_latency", n_in, W + 2);
                end
                if (out_valid && out_ready) begin
                    check("out_addr", 32'(out_addr), n_out);
                    check("out_data", 32'(out_data), model_px(n_out / W, n_out % W, md));
                    got[n_out] = int'(out_data);
                    n_out++;
                    if (n_out == N) begin
                        done = 1;
                        if (start_end) start = 1'b1;
                    end
                end
                if (in_valid && in_ready) n_in++;
                stalled = out_valid && !out_ready;
                hold_d  = out_data;
                hold_a  = out_addr;
            end
            @(negedge clk);
        end
        start     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        if (aborted) begin
            @(negedge clk);
            rst = 1'b1;
        end else begin
            check("frame_complete", n_out, N);
            if (done) begin
                #1;
                check("frame_done_pulse", 32'(frame_done), 1);
                check("busy_low_at_done", 32'(busy), 0);
                check("busy_held",        32'(busy_drop), 0);
                @(negedge clk);
                #1;
                check("frame_done_single", 32'(frame_done), 0);
                check("idle_after_frame",  32'(busy), 0);
            end
        end
    endtask

    initial begin
        int mism;
        rst = 1'b0; start = 1'b0; mode = 2'b00; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("reset_in_ready",   32'(in_ready),   0);
        check("reset_out_valid",  32'(out_valid),  0);
        check("reset_busy",       32'(busy),       0);
        check("reset_frame_done", 32'(frame_done), 0);
        check("reset_out_data",   32'(out_data),   0);
        check("reset_out_addr",   32'(out_addr),   0);
        rst = 1'b1;

        // ramp through passthrough
        for (int i = 0; i < N; i++) img[i] = i;
        run_frame(2'b10, 100, 100, -1, -1, 0);
        check("ramp_interior", got[W + 2], W + 2);
        check("ramp_border",   got[W - 1], 0);

        // vertical step edge through sobel
        for (int i = 0; i < N; i++) img[i] = ((i % W) < W / 2) ? 0 : 255;
        run_frame(2'b01, 100, 100, -1, -1, 0);
        check("sobel_edge_left",  got[W + 3], 255);
        check("sobel_edge_right", got[W + 4], 255);
        check("sobel_flat_left",  got[W + 1], 0);
        check("sobel_flat_right", got[W + 6], 0);

        // single bright pixel: median removes it, gaussian spreads it
        for (int i = 0; i < N; i++) img[i] = 0;
        img[2 * W + 3] = 255;
        run_frame(2'b00, 100, 100, -1, -1, 0);
        check("median_spike", got[2 * W + 3], 0);
        run_frame(2'b11, 100, 100, -1, -1, 0);
        check("gauss_spike",  got[2 * W + 3], 63);
        check("gauss_side",   got[2 * W + 2], 31);

        // random data with backpressure, mid-stream start and start during flush
        for (int i = 0; i < N; i++) img[i] = int'($urandom_range(255));
        run_frame(2'b00, 50, 80, 20, -1, 0);
        for (int i = 0; i < N; i++) img[i] = int'($urandom_range(255));
        run_frame(2'b01, 50, 100, N, -1, 1);

        // same frame with and without backpressure must produce identical output
        for (int i = 0; i < N; i++) img[i] = int'($urandom_range(255));
        run_frame(2'b11, 100, 100, -1, -1, 0);
        for (int i = 0; i < N; i++) ref_q[i] = got[i];
        run_frame(2'b11, 50, 70, -1, -1, 1);
        mism = 0;
        for (int i = 0; i < N; i++) if (got[i] != ref_q[i]) mism++;
        check("stall_vs_nostall", mism, 0);

        // reset mid-frame, then a clean frame
        for (int i = 0; i < N; i++) img[i] = int'($urandom_range(255));
        run_frame(2'b00, 100, 100, -1, 17, 0);
        #1 check("post_reset_idle", 32'(busy), 0);
        run_frame(2'b00, 50, 80, -1, -1, 0);
        run_frame(2'b10, 60, 60, -1, -1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
